// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the processor data-memory request interface. The MEM stage
// issues single-word read/write requests; this block holds the pipeline with
// stall while an access is in flight and pulses done when it completes.
// A direct-mapped, write-through, write-no-allocate cache sits in front of an
// internal backing word array. Every backing access takes LATENCY cycles.
//
// Optional feature macro: DMEM_RESP_CACHE_EN
//   defined     : one-word-per-line cache present; read hits finish in 1 cycle.
//   not defined : no cache storage. Every read goes to the backing array and
//                 cache_hit_o stays 0.
//
// Handshake: a request is (rd_i | wr_i). It is sampled on a rising edge only
// while the FSM is IDLE. After a request is accepted, the requester holds
// addr_i/data_in_i/rd_i/wr_i stable until it sees done_o. Requests made while
// busy are ignored. done_o, err_o and cache_hit_o are one-cycle registered
// pulses. stall_o is high for the whole busy period. done_o and stall_o are
// never high together.
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_ni        asynchronous active-low reset
//   addr_i        byte address (word = addr_i[ADDR_W-1:1]), must be even
//   data_in_i     write data
//   rd_i, wr_i    read / write request
//   createdump_i  halt-time dump request (accepted, no effect)
//   data_out_o    read data, valid with done_o, held until next read completes
//   done_o        completion pulse
//   stall_o       responder busy
//   cache_hit_o   with done_o: the access hit in the cache
//   err_o         illegal request pulse (rd&wr or odd address)
//   state_o       current FSM state (debug)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int LINES     = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic              createdump_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              cache_hit_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  localparam int WA     = ADDR_W - 1;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = WA - IDX_W;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_RD = 2'd1,
    S_BUSY_WR = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WA-1:0]       req_w_q, req_w_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic                hit_lat_q, hit_lat_d;
  logic                done_q, done_d;
  logic                stall_q, stall_d;
  logic                err_q, err_d;
  logic                hit_q, hit_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;

  // Dump requests have no effect on this block.
  logic unused_dump;
  assign unused_dump = createdump_i;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic          req_valid;
  logic          req_illegal;
  logic          accept;
  logic [WA-1:0] in_w;
  logic          cnt_zero;

  assign req_valid   = rd_i | wr_i;
  assign req_illegal = (rd_i & wr_i) | addr_i[0];
  assign in_w        = addr_i[ADDR_W-1:1];
  assign accept      = (state_q == S_IDLE) && req_valid && !req_illegal;
  assign cnt_zero    = (cnt_q == '0);

  // ---------------------------------------------------------------------------
  // Backing word array (not reset). The word address wraps modulo MEM_DEPTH.
  // The write commits only on the completion edge of a write. An async reset
  // forces IDLE, so a write aborted by reset never reaches the array.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [MEM_AW-1:0] req_mem_idx;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rd_data;

  assign req_mem_idx = MEM_AW'(32'(req_w_q) % MEM_DEPTH);
  assign mem_wr_en   = (state_q == S_BUSY_WR) && cnt_zero;
  assign mem_rd_data = mem_q[req_mem_idx];

  always_ff @(posedge clk_i) begin
    if (mem_wr_en) begin
      mem_q[req_mem_idx] <= req_data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Cache lookup and storage
  // ---------------------------------------------------------------------------
  logic              lookup_hit;
  logic [DATA_W-1:0] hit_data;

`ifdef DMEM_RESP_CACHE_EN
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] line_q [LINES];
  logic [IDX_W-1:0]  in_idx;
  logic [TAG_W-1:0]  in_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              fill_en;
  logic              wr_hit_upd;

  assign in_idx  = in_w[IDX_W-1:0];
  assign in_tag  = in_w[WA-1:IDX_W];
  assign req_idx = req_w_q[IDX_W-1:0];
  assign req_tag = req_w_q[WA-1:IDX_W];

  assign lookup_hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign hit_data   = line_q[in_idx];

  // A read miss fills its line when it completes. Any valid line already at
  // that index is simply replaced. The cache is write-through, so that line
  // never needs to be written back.
  assign fill_en    = (state_q == S_BUSY_RD) && cnt_zero;
  // A write hit updates the line on the accept edge. The backing array is
  // written later, when the write completes.
  assign wr_hit_upd = accept && wr_i && lookup_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[req_idx]  <= req_tag;
      line_q[req_idx] <= mem_rd_data;
    end else if (wr_hit_upd) begin
      line_q[in_idx] <= data_in_i;
    end
  end
`else
  assign lookup_hit = 1'b0;
  assign hit_data   = '0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_w_q    <= '0;
      req_data_q <= '0;
      hit_lat_q  <= 1'b0;
      done_q     <= 1'b0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_w_q    <= req_w_d;
      req_data_q <= req_data_d;
      hit_lat_q  <= hit_lat_d;
      done_q     <= done_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      hit_q      <= hit_d;
      data_out_q <= data_out_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // The counter is loaded with LATENCY-1 and the access completes on the edge
  // where it reads 0. This gives exactly LATENCY stall cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (rd_i && !lookup_hit) begin
            state_d = S_BUSY_RD;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else if (wr_i) begin
            state_d = S_BUSY_WR;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      S_BUSY_RD, S_BUSY_WR: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (registered next values) and request capture
  // ---------------------------------------------------------------------------
  always_comb begin
    done_d     = 1'b0;
    stall_d    = 1'b0;
    err_d      = 1'b0;
    hit_d      = 1'b0;
    data_out_d = data_out_q;
    req_w_d    = req_w_q;
    req_data_d = req_data_q;
    hit_lat_d  = hit_lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_illegal) begin
          err_d = 1'b1;
        end else if (accept) begin
          req_w_d    = in_w;
          req_data_d = data_in_i;
          if (rd_i && lookup_hit) begin
            done_d     = 1'b1;
            hit_d      = 1'b1;
            data_out_d = hit_data;
          end else begin
            stall_d   = 1'b1;
            // Only a write reports this; a read miss always reports 0.
            hit_lat_d = wr_i && lookup_hit;
          end
        end
      end
      S_BUSY_RD: begin
        if (cnt_zero) begin
          done_d     = 1'b1;
          data_out_d = mem_rd_data;
        end else begin
          stall_d = 1'b1;
        end
      end
      S_BUSY_WR: begin
        if (cnt_zero) begin
          done_d = 1'b1;
          hit_d  = hit_lat_q;
        end else begin
          stall_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign data_out_o  = data_out_q;
  assign done_o      = done_q;
  assign stall_o     = stall_q;
  assign cache_hit_o = hit_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed sequence plus a short random tail against dmem_responder. Expected
// read data, hit flags and stall lengths come from a small reference model: a
// word store plus a valid/tag table for a direct-mapped, write-no-allocate
// cache. The DMEM_RESP_CACHE_EN macro selects which build is expected.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int LAT = 4;
`ifdef DMEM_RESP_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic        createdump;
  logic [15:0] data_out;
  logic        done;
  logic        stall;
  logic        cache_hit;
  logic        err;
  logic [1:0]  state;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .addr_i       (addr),
    .data_in_i    (data_in),
    .rd_i         (rd),
    .wr_i         (wr),
    .createdump_i (createdump),
    .data_out_o   (data_out),
    .done_o       (done),
    .stall_o      (stall),
    .cache_hit_o  (cache_hit),
    .err_o        (err),
    .state_o      (state)
  );

  // ---------------- scoreboard / model ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic        exp_hit_q[$];
  logic [15:0] model_mem [int];
  bit          m_valid [16];
  logic [10:0] m_tag   [16];
  logic [15:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    last_rd = 16'h0;
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic access(input bit is_wr, input logic [15:0] a, input logic [15:0] d);
    int          w;
    int          idx;
    logic [10:0] tg;
    bit          ehit;
    int          estall;
    int          guard;
    logic [15:0] ed;
    logic        eh;
    w      = int'(a >> 1);
    idx    = int'(a[4:1]);
    tg     = a[15:5];
    ehit   = CACHE && m_valid[idx] && (m_tag[idx] == tg);
    estall = (!is_wr && ehit) ? 0 : LAT;
    if (is_wr) begin
      model_mem[w] = d;
    end else begin
      last_rd = model_mem[w];
      if (CACHE && !ehit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
      end
    end
    exp_q.push_back(last_rd);
    exp_hit_q.push_back(ehit);

    addr    = a;
    data_in = d;
    rd      = !is_wr;
    wr      = is_wr;
    @(negedge clk);
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      check("stall_while_busy", stall, 1'b1);
      guard++;
      @(negedge clk);
    end
    check("done_seen", done, 1'b1);
    check("stall_cycles", guard, estall);
    check("stall_low_at_done", stall, 1'b0);
    check("err_low_at_done", err, 1'b0);
    ed = exp_q.pop_front();
    eh = exp_hit_q.pop_front();
    check(is_wr ? "wr_data_out_held" : "rd_data_out", data_out, ed);
    check("cache_hit", cache_hit, eh);
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
  endtask

  task automatic illegal(input bit r, input bit wv, input logic [15:0] a, input logic [15:0] d);
    addr    = a;
    data_in = d;
    rd      = r;
    wr      = wv;
    @(negedge clk);
    check("err_pulse", err, 1'b1);
    check("err_no_done", done, 1'b0);
    check("err_no_stall", stall, 1'b0);
    check("err_state_idle", state, 2'd0);
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    check("err_one_cycle", err, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          seen_done;
    logic [15:0] ra;
    int          rw;

    rst_n      = 1'b1;
    addr       = 16'h0;
    data_in    = 16'h0;
    rd         = 1'b0;
    wr         = 1'b0;
    createdump = 1'b0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_hit", cache_hit, 1'b0);
    check("rst_data_out", data_out, 16'h0);
    check("rst_state", state, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: write then read miss
    access(1'b1, 16'h0010, 16'hBEEF);
    access(1'b0, 16'h0010, 16'h0000);
    // 2: repeated read of the same word (hit when the cache is built in)
    createdump = 1'b1;
    access(1'b0, 16'h0010, 16'h0000);
    createdump = 1'b0;
    // 3: conflicting tag on index 8
    access(1'b1, 16'h0030, 16'h1234);
    access(1'b0, 16'h0030, 16'h0000);
    access(1'b0, 16'h0010, 16'h0000);
    // 4: write hit updates the line
    access(1'b0, 16'h0010, 16'h0000);
    access(1'b1, 16'h0010, 16'h5555);
    access(1'b0, 16'h0010, 16'h0000);
    // 5: illegal requests leave memory untouched
    illegal(1'b1, 1'b0, 16'h0011, 16'h0000);
    illegal(1'b0, 1'b1, 16'h0013, 16'hFFFF);
    access(1'b1, 16'h0020, 16'h0F0F);
    illegal(1'b1, 1'b1, 16'h0020, 16'hDEAD);
    access(1'b0, 16'h0020, 16'h0000);

    // 6: reset during the second stall cycle aborts the write
    access(1'b1, 16'h0040, 16'h7777);
    addr    = 16'h0040;
    data_in = 16'hAAAA;
    wr      = 1'b1;
    @(negedge clk);
    check("abort_stall_1", stall, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_stall_now", stall, 1'b0);
    check("abort_done_now", done, 1'b0);
    check("abort_state", state, 2'd0);
    wr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 1'b0);
    access(1'b0, 16'h0040, 16'h0000);
    access(1'b0, 16'h0010, 16'h0000);

    // random tail: mixed reads/writes over a small address window
    for (int i = 0; i < 12; i++) begin
      ra = 16'(2 * $urandom_range(0, 47));
      rw = int'(ra >> 1);
      if (model_mem.exists(rw) && ($urandom_range(0, 2) != 0))
        access(1'b0, ra, 16'h0000);
      else
        access(1'b1, ra, 16'($urandom_range(0, 65535)));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
